iir_mac_sequencer: RTL
======================

// Module: iir_mac_sequencer
// PURPOSE
//   Time-multiplexed controller for the 4-tap IIR section
//   y[n] = sum_k b[k]*x[n-k] + (y[n-1]>>>SH1) + (y[n-2]>>>SH2).
//   Uses one shared multiplier and accumulator, stepped by an FSM.
//   Accepts samples over a valid/ready handshake and returns Y over valid/ready.
//   Coefficients are runtime-programmable. Sits between the sample source and the output stage.
// PARAMETERS
//   NBinput   32  input sample width, signed
//   NBoutput  64  accumulator, output and y-history width, signed
//   NBcoef    16  coefficient width, signed
//   NTAPS     4   feedforward taps; coefficient addresses 0..NTAPS-1
//   b0..b3    1,-1,1,1  coefficient reset values
//   SH1       2   arithmetic right shift applied to y[n-1]
//   SH2       4   arithmetic right shift applied to y[n-2]
// PORTS
//   clk         in   1                  clock, rising edge
//   rst         in   1                  synchronous, active-high reset
//   in_valid    in   1                  X is valid
//   in_ready    out  1                  block can accept a sample
//   X           in   NBinput            input sample x[n], signed
//   out_valid   out  1                  Y is valid
//   out_ready   in   1                  downstream accepts Y
//   Y           out  NBoutput           output y[n], signed
//   coef_we     in   1                  coefficient write strobe
//   coef_addr   in   clog2(NTAPS)       coefficient index
//   coef_wdata  in   NBcoef             coefficient value, signed
//   hist_clr    in   1                  zero x/y histories
//   cfg_err     out  1                  one-cycle pulse: write/clear rejected
//   busy        out  1                  FSM not in IDLE
// BEHAVIOUR
//   Reset (rst=1 at clk edge)
//     FSM=IDLE. in_ready=1, out_valid=0, Y=0, cfg_err=0, busy=0.
//     x_hist, y_hist and acc are cleared. coef[k] is loaded with b_k.
//     Reset mid-computation aborts the sample; no output is produced.
//   FSM states: IDLE -> MAC -> FB1 -> FB2 -> OUT -> IDLE
//     IDLE: in_ready=1. On in_valid&in_ready: x_hist shifts, x_hist[0]<=X,
//       acc<=0, idx<=0, go to MAC.
//     MAC: acc += sext(coef[idx]) * sext(x_hist[idx]) each cycle, idx++.
//       Leave after idx=NTAPS-1, i.e. NTAPS cycles.
//     FB1: acc += y_hist[0]>>>SH1.
//     FB2: acc += y_hist[1]>>>SH2.
//     OUT: out_valid=1, Y=acc. Y is held stable while out_ready=0.
//       On out_ready: y_hist[1]<=y_hist[0], y_hist[0]<=acc, go to IDLE.
//       in_ready is 0 in this state; there is no overlap with the next sample.
//   Latency: the accept edge is E0; out_valid is high after edge E(NTAPS+2), which is 6 by default.
//   Throughput: at most 1 sample per NTAPS+4 cycles when out_ready is held at 1.
//   Arithmetic
//     Operands are sign-extended to NBoutput.
//     Products and sums wrap modulo 2^NBoutput; there is no saturation.
//     >>> is an arithmetic shift.
//   Config port
//     coef_we in IDLE writes coef[coef_addr] at the next edge.
//     hist_clr in IDLE zeroes x_hist and y_hist; coefficients are unchanged.
//     If coef_we/hist_clr and an in_valid accept occur in the same IDLE cycle,
//       the config action applies first and the accept proceeds in the same edge.
//       Computation uses the new values.
//     coef_we or hist_clr outside IDLE: ignored; cfg_err=1 for that cycle.
//     coef_addr >= NTAPS: write ignored; cfg_err=1.
// TESTING
//   1. Reset with defaults; send X=16, then 0, 0 -> Y sequence 16, -12, 14.
//      (-12 = -16 + 4; 14 = 16 - 3 + 1)
//   2. In IDLE write coef[0]=3 and issue hist_clr; send X=-5 -> Y=-15.
//      out_valid must rise exactly 6 edges after the accept edge.
//   3. Hold out_ready=0 for 10 cycles in OUT.
//      -> Y stays stable, in_ready stays 0, a pending in_valid is not accepted.
//   4. Assert coef_we during MAC.
//      -> cfg_err pulses for 1 cycle; the coef readback and the current Y are unaffected.
//   5. Assert rst in FB1 -> next cycle out_valid=0, in_ready=1.
//      Next X=7 gives Y=7, so the histories were cleared.
//   6. X=2^31-1 with coef[0]=-2^15.
//      -> Y = -(2^46 - 2^15), i.e. signed, with no truncation at 32 bits.

Source files
------------

// File: rtl/iir_mac_sequencer_if.sv
// Sample, result and coefficient-configuration signals of the IIR MAC sequencer.
// slave is the sequencer side and master is the source/sink side.
interface iir_mac_sequencer_if #(
    parameter int NBinput  = 32,
    parameter int NBoutput = 64,
    parameter int NBcoef   = 16,
    parameter int NTAPS    = 4
);
    localparam int AW = (NTAPS > 1) ? $clog2(NTAPS) : 1;

    logic                       in_valid;
    logic                       in_ready;
    logic signed [NBinput-1:0]  X;
    logic                       out_valid;
    logic                       out_ready;
    logic signed [NBoutput-1:0] Y;
    logic                       coef_we;
    logic [AW-1:0]              coef_addr;
    logic signed [NBcoef-1:0]   coef_wdata;
    logic                       hist_clr;
    logic                       cfg_err;
    logic                       busy;

    modport slave (
        input  in_valid, X, out_ready, coef_we, coef_addr, coef_wdata, hist_clr,
        output in_ready, out_valid, Y, cfg_err, busy
    );

    modport master (
        output in_valid, X, out_ready, coef_we, coef_addr, coef_wdata, hist_clr,
        input  in_ready, out_valid, Y, cfg_err, busy
    );
endinterface

// File: rtl/iir_mac_sequencer.sv
// Time-multiplexed IIR section: one shared multiply-accumulate stepped over the
// feedforward taps, then two shifted feedback terms, then a held output.
module iir_mac_sequencer #(
    parameter int NBinput           = 32,
    parameter int NBoutput          = 64,
    parameter int NBcoef            = 16,
    parameter int NTAPS             = 4,
    parameter int B_RESET [NTAPS]   = '{1, -1, 1, 1},
    parameter int SH1               = 2,
    parameter int SH2               = 4
) (
    input  logic                clk,
    input  logic                rst,
    iir_mac_sequencer_if.slave  bus
);
    localparam int AW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam logic [AW:0] NTAPS_W = (AW + 1)'(NTAPS);
    localparam logic [AW-1:0] LAST_IDX = AW'(NTAPS - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MAC  = 3'd1;
    localparam logic [2:0] S_FB1  = 3'd2;
    localparam logic [2:0] S_FB2  = 3'd3;
    localparam logic [2:0] S_OUT  = 3'd4;

    logic [2:0]                  state_reg, state_next;
    logic [AW-1:0]               idx_reg, idx_next;
    logic signed [NBoutput-1:0]  acc_reg, acc_next;
    logic signed [NBcoef-1:0]    coef_reg [NTAPS];
    logic signed [NBinput-1:0]   x_hist_reg [NTAPS];
    logic signed [NBoutput-1:0]  y_hist_reg [2];

    logic is_idle, accept, addr_ok, coef_wr, clr, out_fire;
    logic signed [NBcoef-1:0]    coef_sel;
    logic signed [NBinput-1:0]   x_sel;
    logic signed [NBoutput-1:0]  coef_ext, x_ext, mac_prod;

    assign is_idle  = (state_reg == S_IDLE);
    assign accept   = is_idle && bus.in_valid;
    assign addr_ok  = ({1'b0, bus.coef_addr} < NTAPS_W);
    assign coef_wr  = is_idle && bus.coef_we && addr_ok;
    assign clr      = is_idle && bus.hist_clr;
    assign out_fire = (state_reg == S_OUT) && bus.out_ready;

    assign bus.in_ready  = is_idle;
    assign bus.out_valid = (state_reg == S_OUT);
    assign bus.Y         = acc_reg;
    assign bus.busy      = !is_idle;
    assign bus.cfg_err   = (!is_idle && (bus.coef_we || bus.hist_clr)) ||
                           (bus.coef_we && !addr_ok);

    // Both operands widened to the accumulator width so the product wraps mod 2^NBoutput.
    assign coef_sel = coef_reg[idx_reg];
    assign x_sel    = x_hist_reg[idx_reg];
    assign coef_ext = {{(NBoutput - NBcoef){coef_sel[NBcoef-1]}}, coef_sel};
    assign x_ext    = {{(NBoutput - NBinput){x_sel[NBinput-1]}}, x_sel};
    assign mac_prod = coef_ext * x_ext;

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        acc_next   = acc_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    acc_next   = '0;
                    idx_next   = '0;
                    state_next = S_MAC;
                end
            end
            S_MAC: begin
                acc_next = acc_reg + mac_prod;
                idx_next = idx_reg + 1'b1;
                if (idx_reg == LAST_IDX) begin
                    state_next = S_FB1;
                end
            end
            S_FB1: begin
                acc_next   = acc_reg + (y_hist_reg[0] >>> SH1);
                state_next = S_FB2;
            end
            S_FB2: begin
                acc_next   = acc_reg + (y_hist_reg[1] >>> SH2);
                state_next = S_OUT;
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            idx_reg   <= '0;
            acc_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            acc_reg   <= acc_next;
        end
    end

    // A clear and an accept in the same cycle leave only the new sample in the history.
    for (genvar gi = 0; gi < NTAPS; gi++) begin : g_taps
        always_ff @(posedge clk) begin
            if (rst) begin
                coef_reg[gi] <= NBcoef'(B_RESET[gi]);
            end else if (coef_wr && (bus.coef_addr == AW'(gi))) begin
                coef_reg[gi] <= bus.coef_wdata;
            end
        end

        if (gi == 0) begin : g_head
            always_ff @(posedge clk) begin
                if (rst) begin
                    x_hist_reg[gi] <= '0;
                end else if (accept) begin
                    x_hist_reg[gi] <= bus.X;
                end else if (clr) begin
                    x_hist_reg[gi] <= '0;
                end
            end
        end else begin : g_tail
            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    x_hist_reg[gi] <= '0;
                end else if (accept) begin
                    x_hist_reg[gi] <= x_hist_reg[gi-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            y_hist_reg[0] <= '0;
            y_hist_reg[1] <= '0;
        end else if (out_fire) begin
            y_hist_reg[1] <= y_hist_reg[0];
            y_hist_reg[0] <= acc_reg;
        end
    end
endmodule
